// File: rtl/bc_pkg.sv
// rtl/bc_pkg.sv - shared constants and select encodings for the bus-connect scheduler
// Contents:
//   REQ_*   requester bit positions in bc_req / bc_gnt
//   drr_sel_e  DRR mux select encodings (pipelined class)
//   di_sel_e   DI mux select encodings (direct class / registered word)
//   di_sel_for_dir  maps a direct-arbiter winner index to its DI select
package bc_pkg;

  localparam int REQ_DG  = 0;
  localparam int REQ_PS  = 1;
  localparam int REQ_XB  = 2;
  localparam int REQ_DM  = 3;
  localparam int REQ_IMM = 4;

  localparam int N_PIPE = 3;
  localparam int N_DIR  = 2;

  typedef enum logic [1:0] {
    DRR_DG   = 2'b00,
    DRR_PS   = 2'b01,
    DRR_XB   = 2'b10,
    DRR_ZERO = 2'b11
  } drr_sel_e;

  typedef enum logic [1:0] {
    DI_DM   = 2'b00,
    DI_PDR  = 2'b01,
    DI_IMM  = 2'b10,
    DI_ZERO = 2'b11
  } di_sel_e;

  // Direct arbiter index 0 is DM, 1 is IMM.
  function automatic di_sel_e di_sel_for_dir(input logic idx);
    return idx ? DI_IMM : DI_DM;
  endfunction

endpackage

// File: rtl/bc_rr_arb.sv
// rtl/bc_rr_arb.sv - rotating-priority arbiter, search starts one past the last winner
// Ports:
//   req  in  N   request vector
//   en   in  1   arbitration enable; no grant when low
//   ptr  in  IW  index of the last winner
//   gnt  out N   one-hot grant
//   idx  out IW  winner index (0 when no winner)
//   vld  out 1   a winner exists this cycle
module bc_rr_arb #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  int   cand;
  logic found;

  // Visit ptr+1, ptr+2, ..., ptr (wrapping); the last winner is checked last.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

  assign vld = found;

endmodule

// File: rtl/bc_sched.sv
// rtl/bc_sched.sv - shares the bc_dt result bus between pipelined and direct requesters
// Ports:
//   clk_dcd         in  1  decode-stage clock
//   rst_n           in  1  asynchronous active-low reset
//   bc_req          in  5  requests: [0]=DG [1]=PS [2]=XB [3]=DM [4]=IMM, held until granted
//   bc_stall        in  1  consumer stall, blocks new grants
//   bc_gnt          out 5  grant pulses, at most one pipelined and one direct bit
//   ps_bc_drr_sclt  out 2  DRR select (00 DG, 01 PS, 10 XB, 11 zero)
//   ps_bc_di_sclt   out 2  DI select (00 DM, 01 registered DRR word, 10 IMM, 11 zero)
//   bc_dt_vld       out 1  bc_dt carries a granted word
//   bc_dt_own       out 3  requester index of the word on bc_dt
//   bc_starve       out 1  pipelined grants suppressed to let a direct request in
module bc_sched
  import bc_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk_dcd,
  input  logic       rst_n,
  input  logic [4:0] bc_req,
  input  logic       bc_stall,
  output logic [4:0] bc_gnt,
  output logic [1:0] ps_bc_drr_sclt,
  output logic [1:0] ps_bc_di_sclt,
  output logic       bc_dt_vld,
  output logic [2:0] bc_dt_own,
  output logic       bc_starve
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             pend;
  logic [1:0]       pend_own;
  logic [1:0]       pipe_ptr;
  logic             dir_ptr;
  logic [CNT_W-1:0] starve_cnt;

  logic             starve_raw;
  logic             pipe_en;
  logic             dir_en;
  logic [2:0]       pipe_gnt;
  logic [1:0]       pipe_idx;
  logic             pipe_vld;
  logic [1:0]       dir_gnt;
  logic             dir_idx;
  logic             dir_vld;
  logic             dir_req;

  assign starve_raw = (starve_cnt >= STARVE_LIM);
  assign dir_req    = bc_req[REQ_DM] | bc_req[REQ_IMM];

  // rst_n in the enables keeps grants idle while reset is asserted even
  // though bc_req may already be active.
  assign pipe_en = rst_n && !bc_stall && !starve_raw;
  // A pending word owns the DI mux this cycle, so the direct class waits.
  assign dir_en  = rst_n && !bc_stall && !pend;

  bc_rr_arb #(.N(N_PIPE), .IW(2)) u_pipe_arb (
    .req (bc_req[REQ_XB:REQ_DG]),
    .en  (pipe_en),
    .ptr (pipe_ptr),
    .gnt (pipe_gnt),
    .idx (pipe_idx),
    .vld (pipe_vld)
  );

  bc_rr_arb #(.N(N_DIR), .IW(1)) u_dir_arb (
    .req (bc_req[REQ_IMM:REQ_DM]),
    .en  (dir_en),
    .ptr (dir_ptr),
    .gnt (dir_gnt),
    .idx (dir_idx),
    .vld (dir_vld)
  );

  always_comb begin
    bc_gnt         = 5'b0;
    ps_bc_drr_sclt = DRR_ZERO;
    ps_bc_di_sclt  = DI_ZERO;
    bc_dt_vld      = 1'b0;
    bc_dt_own      = 3'd0;
    bc_starve      = 1'b0;
    if (rst_n) begin
      bc_gnt    = {dir_gnt, pipe_gnt};
      bc_starve = starve_raw;
      if (pipe_vld) begin
        ps_bc_drr_sclt = pipe_idx;
      end
      if (dir_vld) begin
        ps_bc_di_sclt = di_sel_for_dir(dir_idx);
        bc_dt_vld     = 1'b1;
        bc_dt_own     = dir_idx ? 3'(REQ_IMM) : 3'(REQ_DM);
      end
      // dir_en already excludes a direct grant when pend is set; this
      // ordering states the priority of the captured word explicitly.
      if (pend) begin
        ps_bc_di_sclt = DI_PDR;
        bc_dt_vld     = 1'b1;
        bc_dt_own     = {1'b0, pend_own};
      end
    end
  end

  // pend is not held on stall: the captured word is always delivered the
  // cycle after its grant, and stall only prevents a new capture.
  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_own   <= 2'd0;
      pipe_ptr   <= 2'd2;
      dir_ptr    <= 1'b1;
      starve_cnt <= '0;
    end else begin
      pend <= pipe_vld;
      if (pipe_vld) begin
        pend_own <= pipe_idx;
        pipe_ptr <= pipe_idx;
      end
      if (dir_vld) begin
        dir_ptr <= dir_idx;
      end
      if (!bc_stall) begin
        if (dir_req && !dir_vld) begin
          if (starve_cnt != '1) begin
            starve_cnt <= starve_cnt + CNT_ONE;
          end
        end else begin
          starve_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bc_sched.sv
// tb/tb_bc_sched.sv - directed vector table plus randomized reference-model check of bc_sched
module tb_bc_sched;

  localparam int STARVE_MAX = 4;
  localparam int CNT_MAXV   = 15;

  logic       clk_dcd;
  logic       rst_n;
  logic [4:0] bc_req;
  logic       bc_stall;
  logic [4:0] bc_gnt;
  logic [1:0] ps_bc_drr_sclt;
  logic [1:0] ps_bc_di_sclt;
  logic       bc_dt_vld;
  logic [2:0] bc_dt_own;
  logic       bc_starve;

  int n_tests;
  int n_fail;

  bc_sched #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .clk_dcd        (clk_dcd),
    .rst_n          (rst_n),
    .bc_req         (bc_req),
    .bc_stall       (bc_stall),
    .bc_gnt         (bc_gnt),
    .ps_bc_drr_sclt (ps_bc_drr_sclt),
    .ps_bc_di_sclt  (ps_bc_di_sclt),
    .bc_dt_vld      (bc_dt_vld),
    .bc_dt_own      (bc_dt_own),
    .bc_starve      (bc_starve)
  );

  initial clk_dcd = 1'b0;
  always #5 clk_dcd = ~clk_dcd;

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic       stall;
    logic [4:0] gnt;
    logic [1:0] drr;
    logic [1:0] di;
    logic       vld;
    logic [2:0] own;
    logic       starve;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [4:0] q, input logic s,
                     input logic [4:0] g, input logic [1:0] d, input logic [1:0] i,
                     input logic v, input logic [2:0] o, input logic st);
    vec_t e;
    e.rst = r; e.req = q; e.stall = s; e.gnt = g; e.drr = d;
    e.di = i; e.vld = v; e.own = o; e.starve = st;
    vq.push_back(e);
  endtask

  task automatic check(input string name, input int cyc, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_all(input int cyc, input logic [4:0] g, input logic [1:0] d,
                           input logic [1:0] i, input logic v, input logic [2:0] o,
                           input logic st);
    check("gnt",    cyc, int'(bc_gnt),         int'(g));
    check("drr",    cyc, int'(ps_bc_drr_sclt), int'(d));
    check("di",     cyc, int'(ps_bc_di_sclt),  int'(i));
    check("vld",    cyc, int'(bc_dt_vld),      int'(v));
    check("own",    cyc, int'(bc_dt_own),      int'(o));
    check("starve", cyc, int'(bc_starve),      int'(st));
  endtask

  // Reference model: bus ownership described as "who was last served" and
  // "how many cycles has the direct class waited", evaluated from the rules.
  int m_pend;
  int m_pown;
  int m_plast;
  int m_dlast;
  int m_wait;

  task automatic model_reset();
    m_pend = 0; m_pown = 0; m_plast = 2; m_dlast = 1; m_wait = 0;
  endtask

  task automatic model_cycle(input int cyc, input logic r, input logic [4:0] q, input logic s);
    logic [4:0] eg;
    logic [1:0] ed, ei;
    logic       ev, est;
    logic [2:0] eo;
    int pw, dw, c;
    eg = 5'b0; ed = 2'd3; ei = 2'd3; ev = 1'b0; eo = 3'd0; est = 1'b0;
    pw = -1; dw = -1;
    if (!r) model_reset();
    if (r) begin
      est = (m_wait >= STARVE_MAX);
      if (!s && !est) begin
        for (int k = 1; k <= 3; k++) begin
          c = (m_plast + k) % 3;
          if (pw < 0 && q[c]) pw = c;
        end
      end
      if (!s && m_pend == 0) begin
        for (int k = 1; k <= 2; k++) begin
          c = (m_dlast + k) % 2;
          if (dw < 0 && q[3 + c]) dw = c;
        end
      end
      if (pw >= 0) begin eg[pw] = 1'b1; ed = 2'(pw); end
      if (dw >= 0) begin
        eg[3 + dw] = 1'b1; ei = (dw == 0) ? 2'd0 : 2'd2; ev = 1'b1; eo = 3'(3 + dw);
      end
      if (m_pend != 0) begin ei = 2'd1; ev = 1'b1; eo = 3'(m_pown); end
    end
    check_all(cyc, eg, ed, ei, ev, eo, est);
    if (r) begin
      m_pend = (pw >= 0) ? 1 : 0;
      if (pw >= 0) begin m_pown = pw; m_plast = pw; end
      if (dw >= 0) m_dlast = dw;
      if (!s) begin
        if ((q[3] || q[4]) && dw < 0) m_wait = (m_wait < CNT_MAXV) ? m_wait + 1 : CNT_MAXV;
        else m_wait = 0;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n    = 1'b0;
    bc_req   = 5'b0;
    bc_stall = 1'b0;

    //  rst req       stl gnt       drr  di   vld own st
    // reset with all requesting, then DG+DM first after release
    add(0, 5'b11111, 0, 5'b00000, 2'd3, 2'd3, 0, 3'd0, 0);
    add(1, 5'b11111, 0, 5'b01001, 2'd0, 2'd0, 1, 3'd3, 0);
    add(1, 5'b00000, 0, 5'b00000, 2'd3, 2'd1, 1, 3'd0, 0);
    // single PS, one-cycle latency
    add(1, 5'b00010, 0, 5'b00010, 2'd1, 2'd3, 0, 3'd0, 0);
    add(1, 5'b00000, 0, 5'b00000, 2'd3, 2'd1, 1, 3'd1, 0);
    // PS then stall with DG requesting: word still delivered, DG waits
    add(1, 5'b00010, 0, 5'b00010, 2'd1, 2'd3, 0, 3'd0, 0);
    add(1, 5'b00001, 1, 5'b00000, 2'd3, 2'd1, 1, 3'd1, 0);
    add(1, 5'b00001, 0, 5'b00001, 2'd0, 2'd3, 0, 3'd0, 0);
    add(1, 5'b00000, 0, 5'b00000, 2'd3, 2'd1, 1, 3'd0, 0);
    // DM and IMM alternating (DM served last, so IMM leads)
    add(1, 5'b11000, 0, 5'b10000, 2'd3, 2'd2, 1, 3'd4, 0);
    add(1, 5'b11000, 0, 5'b01000, 2'd3, 2'd0, 1, 3'd3, 0);
    add(1, 5'b11000, 0, 5'b10000, 2'd3, 2'd2, 1, 3'd4, 0);
    add(1, 5'b01000, 0, 5'b01000, 2'd3, 2'd0, 1, 3'd3, 0);
    // XB granted then reset: captured word discarded
    add(1, 5'b00100, 0, 5'b00100, 2'd2, 2'd3, 0, 3'd0, 0);
    add(0, 5'b00000, 0, 5'b00000, 2'd3, 2'd3, 0, 3'd0, 0);
    add(1, 5'b00000, 0, 5'b00000, 2'd3, 2'd3, 0, 3'd0, 0);
    // DG/XB streaming, DM starves for 4 cycles then wins
    add(1, 5'b00101, 0, 5'b00001, 2'd0, 2'd3, 0, 3'd0, 0);
    add(1, 5'b00101, 0, 5'b00100, 2'd2, 2'd1, 1, 3'd0, 0);
    add(1, 5'b01101, 0, 5'b00001, 2'd0, 2'd1, 1, 3'd2, 0);
    add(1, 5'b01101, 0, 5'b00100, 2'd2, 2'd1, 1, 3'd0, 0);
    add(1, 5'b01101, 0, 5'b00001, 2'd0, 2'd1, 1, 3'd2, 0);
    add(1, 5'b01101, 0, 5'b00100, 2'd2, 2'd1, 1, 3'd0, 0);
    add(1, 5'b01101, 0, 5'b00000, 2'd3, 2'd1, 1, 3'd2, 1);
    add(1, 5'b01101, 0, 5'b01000, 2'd3, 2'd0, 1, 3'd3, 1);
    add(1, 5'b00101, 0, 5'b00001, 2'd0, 2'd3, 0, 3'd0, 0);
    add(1, 5'b00000, 0, 5'b00000, 2'd3, 2'd1, 1, 3'd0, 0);

    for (int n = 0; n < vq.size(); n++) begin
      rst_n    = vq[n].rst;
      bc_req   = vq[n].req;
      bc_stall = vq[n].stall;
      #4;
      check_all(n, vq[n].gnt, vq[n].drr, vq[n].di, vq[n].vld, vq[n].own, vq[n].starve);
      @(posedge clk_dcd);
      #1;
    end

    // Randomized phase against the reference model, starting from reset.
    for (int n = 0; n < 3000; n++) begin
      logic       r;
      logic [4:0] q;
      logic       s;
      r = (n < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
      q = 5'($urandom);
      if ($urandom_range(0, 3) == 0) q[4:3] = 2'b00;
      s = ($urandom_range(0, 4) == 0);
      rst_n    = r;
      bc_req   = q;
      bc_stall = s;
      #4;
      model_cycle(1000 + n, r, q, s);
      @(posedge clk_dcd);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
